mem_stage_ctrl: RTL and testbench

Memory-access stage controller between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes a decoded load/store (address, store data, control bits) from EX/MEM.
- Runs a req/ack transaction with variable-latency data memory and stalls upstream until done.
- Presents address, load data, Rd and writeback control to MEM/WB.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_stage_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-access stage between EX/MEM and MEM/WB; runs a req/ack
// transaction with variable-latency data memory and passes non-memory ops through.
// Latency: ALU ops 1 cycle; memory ops 1 + (BUSY cycles until ack or timeout).
// Backpressure: stall_o holds EX/MEM while a memory op is issuing or waiting for ack.
// Optional: define MEM_STAGE_ALIGN_CHECK_EN to reject word-misaligned loads/stores.

module mem_stage_ctrl #(
    // Max BUSY cycles spent waiting for ack before abort; 0 disables the timeout.
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    // EX/MEM side
    input  logic        valid_i,
    input  logic [31:0] MemAddr_i,
    input  logic [31:0] MemWrite_Data_i,
    input  logic [4:0]  Rd_Addr_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    output logic        stall_o,

    // Data memory side
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,

    // MEM/WB side
    output logic        valid_o,
    output logic [31:0] MemAddr_o,
    output logic [31:0] MemRead_Data_o,
    output logic [4:0]  Rd_Addr_o,
    output logic        RegWrite_o,
    output logic        MemToReg_o,
    output logic        err_o,
    output logic        misalign_o
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit.
    localparam int CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
    localparam bit   TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;

    // Transaction held for the whole of BUSY
    logic          r_req;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_is_load;
    logic [4:0]    r_rd;
    logic          r_rw;
    logic          r_m2r;

    // Registered MEM/WB outputs
    logic          r_valid_o;
    logic [31:0]   r_memaddr_o;
    logic [31:0]   r_rdata_o;
    logic [4:0]    r_rd_o;
    logic          r_rw_o;
    logic          r_m2r_o;
    logic          r_err_o;

    logic          w_memop;
    logic          w_misalign;
    logic          w_issue;
    logic          w_timeout_hit;

    assign w_memop = valid_i & (MemRead_i | MemWrite_i);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic          r_mis_o;
    assign w_misalign = w_memop & (MemAddr_i[1:0] != 2'b00);
    assign misalign_o = r_mis_o;
`else
    assign w_misalign = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // A misaligned op completes like a bubble with a flag; it never reaches memory.
    assign w_issue = w_memop & ~w_misalign;

    // Last permitted BUSY cycle with no ack: abort this cycle, release the stall.
    assign w_timeout_hit = TO_EN & (r_state == ST_BUSY) & ~dmem_ack_i & (r_cnt == TO_LAST);

    // Stall while an op is being issued, or while waiting on memory; released in the
    // ack/abort cycle so the next instruction lands in the cycle after completion.
    // Reset forces it low even while EX/MEM still presents the abandoned op.
    assign stall_o = ~rst_i & (((r_state == ST_IDLE) & w_issue) |
                               ((r_state == ST_BUSY) & ~dmem_ack_i & ~w_timeout_hit));

    assign dmem_req_o     = r_req;
    assign dmem_we_o      = r_we;
    assign dmem_addr_o    = r_addr;
    assign dmem_wdata_o   = r_wdata;

    assign valid_o        = r_valid_o;
    assign MemAddr_o      = r_memaddr_o;
    assign MemRead_Data_o = r_rdata_o;
    assign Rd_Addr_o      = r_rd_o;
    assign RegWrite_o     = r_rw_o;
    assign MemToReg_o     = r_m2r_o;
    assign err_o          = r_err_o;

    // Stage FSM: accepts instructions in IDLE, tracks the memory transaction in BUSY
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_load   <= 1'b0;
            r_rd        <= '0;
            r_rw        <= 1'b0;
            r_m2r       <= 1'b0;
            r_valid_o   <= 1'b0;
            r_memaddr_o <= '0;
            r_rdata_o   <= '0;
            r_rd_o      <= '0;
            r_rw_o      <= 1'b0;
            r_m2r_o     <= 1'b0;
            r_err_o     <= 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            r_mis_o     <= 1'b0;
`endif
        end else begin
            // Completion strobes are single-cycle; data fields hold unless overwritten.
            r_valid_o <= 1'b0;
            r_rw_o    <= 1'b0;
            r_err_o   <= 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            r_mis_o   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (valid_i) begin
                        if (w_issue) begin
                            r_req     <= 1'b1;
                            r_we      <= MemWrite_i;
                            r_addr    <= MemAddr_i;
                            r_wdata   <= MemWrite_Data_i;
                            // Read+write together behaves as a store: no read data.
                            r_is_load <= MemRead_i & ~MemWrite_i;
                            r_rd      <= Rd_Addr_i;
                            r_rw      <= RegWrite_i;
                            r_m2r     <= MemToReg_i;
                            r_state   <= ST_BUSY;
                        end else begin
                            r_valid_o   <= 1'b1;
                            r_memaddr_o <= MemAddr_i;
                            r_rdata_o   <= '0;
                            r_rd_o      <= Rd_Addr_i;
                            r_m2r_o     <= MemToReg_i;
                            // x0 is never written back.
                            r_rw_o      <= RegWrite_i & (Rd_Addr_i != 5'd0) & ~w_misalign;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
                            r_mis_o     <= w_misalign;
`endif
                        end
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack_i) begin
                        r_req       <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_IDLE;
                        r_valid_o   <= 1'b1;
                        r_memaddr_o <= r_addr;
                        r_rdata_o   <= r_is_load ? dmem_rdata_i : 32'd0;
                        r_rd_o      <= r_rd;
                        r_rw_o      <= r_rw & (r_rd != 5'd0);
                        r_m2r_o     <= r_m2r;
                    end else if (w_timeout_hit) begin
                        // Abort: retire the instruction without writeback and flag it.
                        r_req       <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_IDLE;
                        r_valid_o   <= 1'b1;
                        r_memaddr_o <= r_addr;
                        r_rdata_o   <= '0;
                        r_rd_o      <= r_rd;
                        r_m2r_o     <= r_m2r;
                        r_err_o     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: drives directed and random instructions through mem_stage_ctrl
// with a responder of chosen latency; expectations come from a per-instruction
// outcome model (stall length, request length, retired record).

module tb_mem_stage_ctrl;

    localparam int TO = 4;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] MemAddr_i;
    logic [31:0] MemWrite_Data_i;
    logic [4:0]  Rd_Addr_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        RegWrite_i;
    logic        MemToReg_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        valid_o;
    logic [31:0] MemAddr_o;
    logic [31:0] MemRead_Data_o;
    logic [4:0]  Rd_Addr_o;
    logic        RegWrite_o;
    logic        MemToReg_o;
    logic        err_o;
    logic        misalign_o;

    always #5 clk_i = ~clk_i;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .valid_i         (valid_i),
        .MemAddr_i       (MemAddr_i),
        .MemWrite_Data_i (MemWrite_Data_i),
        .Rd_Addr_i       (Rd_Addr_i),
        .MemRead_i       (MemRead_i),
        .MemWrite_i      (MemWrite_i),
        .RegWrite_i      (RegWrite_i),
        .MemToReg_i      (MemToReg_i),
        .stall_o         (stall_o),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_ack_i      (dmem_ack_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .valid_o         (valid_o),
        .MemAddr_o       (MemAddr_o),
        .MemRead_Data_o  (MemRead_Data_o),
        .Rd_Addr_o       (Rd_Addr_o),
        .RegWrite_o      (RegWrite_o),
        .MemToReg_o      (MemToReg_o),
        .err_o           (err_o),
        .misalign_o      (misalign_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        err;
        logic        mis;
    } res_t;

    int          n_chk = 0;
    int          n_err = 0;
    logic        pend  = 1'b0;   // a retired instruction is due on the outputs
    res_t        pres;
    logic [31:0] last_addr = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: the retired record (if any) must be visible exactly now.
    task automatic sample_outputs();
        check("valid_o", {31'd0, valid_o}, {31'd0, pend});
        check("err_o", {31'd0, err_o}, {31'd0, pend & pres.err});
        check("misalign_o", {31'd0, misalign_o}, {31'd0, pend & pres.mis});
        if (pend) begin
            check("MemAddr_o", MemAddr_o, pres.addr);
            check("MemRead_Data_o", MemRead_Data_o, pres.rdata);
            check("Rd_Addr_o", {27'd0, Rd_Addr_o}, {27'd0, pres.rd});
            check("RegWrite_o", {31'd0, RegWrite_o}, {31'd0, pres.rw});
            check("MemToReg_o", {31'd0, MemToReg_o}, {31'd0, pres.m2r});
            last_addr = pres.addr;
            pend      = 1'b0;
        end else begin
            check("RegWrite_o_novalid", {31'd0, RegWrite_o}, 32'd0);
        end
    endtask

    // One bubble cycle; a stray ack is thrown in to show it is ignored in IDLE.
    task automatic idle_cycle();
        logic had_pend;
        had_pend        = pend;
        valid_i         = 1'b0;
        MemRead_i       = $urandom_range(0, 1);
        MemWrite_i      = $urandom_range(0, 1);
        MemAddr_i       = $urandom;
        Rd_Addr_i       = 5'($urandom);
        RegWrite_i      = $urandom_range(0, 1);
        dmem_ack_i      = $urandom_range(0, 1);
        dmem_rdata_i    = $urandom;
        @(negedge clk_i);
        sample_outputs();
        check("idle_stall", {31'd0, stall_o}, 32'd0);
        check("idle_req", {31'd0, dmem_req_o}, 32'd0);
        if (!had_pend) check("idle_hold_addr", MemAddr_o, last_addr);
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
    endtask

    // Present one instruction, hold it while stalled, answer memory after 'lat'
    // BUSY cycles (lat >= TO means never), then queue its expected retired record.
    task automatic do_instr(input logic ld, input logic st, input logic rw, input logic m2r,
                            input logic [4:0] rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
        logic memop, mis, issue, tmo;
        int   nreq, ns, nr, c;
        bit   done;
        memop = ld | st;
        mis   = ALIGN && memop && (addr[1:0] != 2'b00);
        issue = memop && !mis;
        tmo   = issue && (lat >= TO);
        nreq  = !issue ? 0 : ((lat < TO) ? lat + 1 : TO);
        ns = 0; nr = 0; c = 0; done = 0;

        valid_i = 1'b1; MemRead_i = ld; MemWrite_i = st; RegWrite_i = rw;
        MemToReg_i = m2r; Rd_Addr_i = rd; MemAddr_i = addr; MemWrite_Data_i = wdata;
        while (!done) begin
            dmem_ack_i   = (c == 0) ? 1'($urandom_range(0, 1)) : (issue && (c == lat + 1));
            dmem_rdata_i = (issue && c == lat + 1) ? rdata : $urandom;
            @(negedge clk_i);
            sample_outputs();
            if (c == 0) check("req_before_issue", {31'd0, dmem_req_o}, 32'd0);
            if (dmem_req_o) begin
                check("dmem_addr_o", dmem_addr_o, addr);
                check("dmem_we_o", {31'd0, dmem_we_o}, {31'd0, st});
                check("dmem_wdata_o", dmem_wdata_o, wdata);
            end
            ns += int'(stall_o);
            nr += int'(dmem_req_o);
            if (!stall_o) done = 1;
            else if (c >= TO + 2) begin
                check("stall_bound", {31'd0, stall_o}, 32'd0);
                done = 1;
            end
            @(posedge clk_i); #1;
            c++;
        end
        valid_i    = 1'b0;
        dmem_ack_i = 1'b0;
        check("stall_cycles", ns, nreq);
        check("req_cycles", nr, nreq);

        pend       = 1'b1;
        pres.addr  = addr;
        pres.rdata = (ld && !st && issue && !tmo) ? rdata : 32'd0;
        pres.rd    = rd;
        pres.rw    = rw && (rd != 5'd0) && !tmo && !mis;
        pres.m2r   = m2r;
        pres.err   = tmo;
        pres.mis   = mis;
    endtask

    initial begin
        logic [31:0] a;
        int          kind;

        rst_i = 1'b1; valid_i = 1'b0; MemAddr_i = '0; MemWrite_Data_i = '0; Rd_Addr_i = '0;
        MemRead_i = 1'b0; MemWrite_i = 1'b0; RegWrite_i = 1'b0; MemToReg_i = 1'b0;
        dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        #1;
        check("rst_valid_o", {31'd0, valid_o}, 32'd0);
        check("rst_req", {31'd0, dmem_req_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_MemAddr_o", MemAddr_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // ALU pass-through, then same with x0 destination
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 0, 32'h0);
        do_instr(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234, 32'h0, 0, 32'h0);
        idle_cycle();
        // Load, ack in third BUSY cycle
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h40, 32'h0, 2, 32'hDEADBEEF);
        idle_cycle();
        // Zero-wait store followed back-to-back by a load
        do_instr(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h80, 32'hA5A5A5A5, 0, 32'h0);
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h84, 32'h0, 1, 32'h13572468);
        // Timeout, and an ack landing on the last allowed cycle
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h100, 32'h0, 50, 32'h0);
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h104, 32'h0, TO - 1, 32'hCAFEF00D);
        // Misaligned load (flagged only with the alignment check built in)
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h42, 32'h0, 1, 32'h0BADF00D);
        // Read and write both set: behaves as a store
        do_instr(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 32'h200, 32'h11112222, 1, 32'h99999999);
        idle_cycle();

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            kind = $urandom_range(0, 3);
            do_instr(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                     a, $urandom, $urandom_range(0, TO + 1), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        // Reset in the middle of a transaction; a late ack must not retire anything
        valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; MemAddr_i = 32'h300;
        RegWrite_i = 1'b1; Rd_Addr_i = 5'd3; MemToReg_i = 1'b1; dmem_ack_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("pre_rst_req", {31'd0, dmem_req_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        check("rst_mid_req", {31'd0, dmem_req_o}, 32'd0);
        check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
        check("rst_mid_valid", {31'd0, valid_o}, 32'd0);
        valid_i = 1'b0; MemRead_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h12345678;
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
        @(negedge clk_i);
        check("late_ack_valid", {31'd0, valid_o}, 32'd0);
        check("late_ack_req", {31'd0, dmem_req_o}, 32'd0);
        check("late_ack_rdata", MemRead_Data_o, 32'd0);
        @(posedge clk_i); #1;
        pend = 1'b0; last_addr = 32'd0;
        idle_cycle();
        do_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h400, 32'h0, 0, 32'h5A5A0F0F);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
